ntt_coef_loader: RTL and testbench

//  Upstream feeder for the NTT wrap core. Accepts 32-bit words of two packed
//  16-bit coefficients over a valid/ready stream and reduces each coefficient once mod Q.

---
 rtl/ntt_coef_loader.sv | 138 +++++++++++++
 tb/tb_ntt_coef_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_coef_loader.sv
// Streams packed coefficient pairs into the NTT wrap core input memory, reducing each once mod Q.
// Write latency is 1 cycle from accept; s_ready is high only in LOAD, so upstream stalls elsewhere.
module ntt_coef_loader #(
    parameter int N            = 256,
    parameter int Q            = 3329,
    parameter int INIT_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [31:0]            s_data,
    input  logic                   init_done,
    output logic                   we,
    output logic [$clog2(N)-1:0]   address_ina,
    output logic [$clog2(N)-1:0]   address_inb,
    output logic [15:0]            data_ina,
    output logic [15:0]            data_inb,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   err_range,
    output logic                   err_timeout
);

    localparam int AW = $clog2(N);
    localparam int KW = AW - 1;
    localparam int TW = $clog2(INIT_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        FLUSH     = 3'd2,
        WAIT_INIT = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [TW-1:0]   r_timer;
    logic            r_we;
    logic [AW-1:0]   r_addr_a;
    logic [AW-1:0]   r_addr_b;
    logic [15:0]     r_data_a;
    logic [15:0]     r_data_b;
    logic            r_err_range;
    logic            r_err_timeout;

    logic            w_accept;
    logic [15:0]     w_coef_a;
    logic [15:0]     w_coef_b;
    logic            w_out_of_range;
    logic            w_last_pair;

    function automatic logic [15:0] reduce_once(input logic [15:0] c);
        return (c >= 16'(Q)) ? c - 16'(Q) : c;
    endfunction

    assign s_ready        = (r_state == LOAD);
    assign w_accept       = s_valid && s_ready;
    assign w_coef_a       = s_data[15:0];
    assign w_coef_b       = s_data[31:16];
    // Anything at or above 2Q cannot be brought into range by one subtraction.
    assign w_out_of_range = (w_coef_a >= 16'(2 * Q)) || (w_coef_b >= 16'(2 * Q));
    assign w_last_pair    = (r_k == KW'(N / 2 - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_timer       <= '0;
            r_we          <= 1'b0;
            r_addr_a      <= '0;
            r_addr_b      <= '0;
            r_data_a      <= '0;
            r_data_b      <= '0;
            r_err_range   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr_a <= {r_k, 1'b0};
                r_addr_b <= {r_k, 1'b1};
                r_data_a <= reduce_once(w_coef_a);
                r_data_b <= reduce_once(w_coef_b);
                r_k      <= r_k + KW'(1);
                if (w_out_of_range) begin
                    r_err_range <= 1'b1;
                end
            end

            case (r_state)
                IDLE, DONE: begin
                    if (load_start) begin
                        r_state       <= LOAD;
                        r_k           <= '0;
                        r_timer       <= '0;
                        r_err_range   <= 1'b0;
                        r_err_timeout <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_accept && w_last_pair) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_state <= WAIT_INIT;
                end
                WAIT_INIT: begin
                    // init_done wins over a timeout landing in the same cycle.
                    if (init_done) begin
                        r_state <= DONE;
                    end else if (r_timer == TW'(INIT_TIMEOUT - 1)) begin
                        r_state       <= DONE;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign we          = r_we;
    assign address_ina = r_addr_a;
    assign address_inb = r_addr_b;
    assign data_ina    = r_data_a;
    assign data_inb    = r_data_b;
    assign load_busy   = (r_state == LOAD) || (r_state == FLUSH) || (r_state == WAIT_INIT);
    assign load_done   = (r_state == DONE);
    assign err_range   = r_err_range;
    assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Scoreboard bench for ntt_coef_loader: driver pushes expected writes, a negedge monitor pops them.
module tb_ntt_coef_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_start = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        init_done = 1'b0;
    logic        we;
    logic [7:0]  address_ina;
    logic [7:0]  address_inb;
    logic [15:0] data_ina;
    logic [15:0] data_inb;
    logic        load_busy;
    logic        load_done;
    logic        err_range;
    logic        err_timeout;

    ntt_coef_loader #(.N(256), .Q(3329), .INIT_TIMEOUT(4096)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .init_done(init_done), .we(we),
        .address_ina(address_ina), .address_inb(address_inb),
        .data_ina(data_ina), .data_inb(data_inb),
        .load_busy(load_busy), .load_done(load_done),
        .err_range(err_range), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] da;
        logic [15:0] db;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   exp_k = 0;

    function automatic logic [15:0] red(input logic [15:0] c);
        return (c >= 16'd3329) ? c - 16'd3329 : c;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            chk("write_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk("write", {16'd0, address_ina, address_inb, data_ina, data_inb}, {16'd0, mon_e});
            end
        end
    end

    task automatic send(input logic [15:0] lo, input logic [15:0] hi);
        int w;
        w = 0;
        s_valid = 1'b1;
        s_data  = {hi, lo};
        while (!s_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            chk("send_ready", 64'(s_ready), 64'd1);
        end else begin
            q.push_back({8'(2 * exp_k), 8'(2 * exp_k + 1), red(lo), red(hi)});
            exp_k++;
        end
        @(negedge clk);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        exp_k = 0;
    endtask

    task automatic finish_init(input int delay);
        repeat (delay) @(negedge clk);
        init_done = 1'b1;
        chk("done_before_init", 64'(load_done), 64'd0);
        @(negedge clk);
        init_done = 1'b0;
        chk("done_after_init", 64'(load_done), 64'd1);
        chk("busy_after_init", 64'(load_busy), 64'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"}, 64'(we), 64'd0);
        chk({tag, "_addr"}, {48'd0, address_ina, address_inb}, 64'd0);
        chk({tag, "_data"}, {32'd0, data_ina, data_inb}, 64'd0);
        chk({tag, "_busy_done"}, {62'd0, load_busy, load_done}, 64'd0);
        chk({tag, "_errs"}, {62'd0, err_range, err_timeout}, 64'd0);
        chk({tag, "_ready"}, 64'(s_ready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // T1: back-to-back load, data equals address
        start_load();
        chk("t1_ready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 128; i++) send(16'(2 * i), 16'(2 * i + 1));
        s_valid = 1'b0;
        chk("t1_ready_flush", 64'(s_ready), 64'd0);
        chk("t1_busy_flush", 64'(load_busy), 64'd1);
        finish_init(5);

        // T2: random bubbles
        start_load();
        for (int i = 0; i < 128; i++) begin
            send(16'(2 * i), 16'(2 * i + 1));
            if (i != 127 && $urandom_range(0, 1) == 1) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        finish_init(2);

        // T3 + T5: reduction corner values, sticky err_range, init timeout
        start_load();
        send(16'd3328, 16'd3329);
        chk("t3_data_a0", 64'(data_ina), 64'd3328);
        chk("t3_data_b0", 64'(data_inb), 64'd0);
        chk("t3_err_clear", 64'(err_range), 64'd0);
        send(16'd6658, 16'd65535);
        chk("t3_data_a1", 64'(data_ina), 64'd3329);
        chk("t3_data_b1", 64'(data_inb), 64'd62206);
        chk("t3_err_set", 64'(err_range), 64'd1);
        for (int i = 2; i < 128; i++) send(16'(2 * i), 16'(2 * i + 1));
        s_valid = 1'b0;
        repeat (4096) @(negedge clk);
        chk("t5_still_waiting", {62'd0, load_busy, load_done}, 64'd2);
        chk("t5_no_timeout_yet", 64'(err_timeout), 64'd0);
        @(negedge clk);
        chk("t5_done", 64'(load_done), 64'd1);
        chk("t5_timeout", 64'(err_timeout), 64'd1);
        chk("t3_err_sticky", 64'(err_range), 64'd1);
        chk("t5_queue", 64'(q.size()), 64'd0);
        start_load();
        chk("t5_errs_cleared", {62'd0, err_range, err_timeout}, 64'd0);
        chk("t5_reload_busy", 64'(load_busy), 64'd1);

        // T4: reset after 40 accepts, with s_valid still asserted
        for (int i = 0; i < 40; i++) send(16'(2 * i), 16'(2 * i + 1));
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("t4_rst");
        repeat (2) @(negedge clk);
        chk("t4_rst_we_hold", 64'(we), 64'd0);
        rst = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("t4_idle_after_rst", {61'd0, load_busy, load_done, we}, 64'd0);

        // T4/T6: restart from address 0, load_start mid-load and with final accept, extra words
        start_load();
        send(16'd0, 16'd1);
        chk("t4_restart_addr", {48'd0, address_ina, address_inb}, 64'h0001);
        for (int i = 1; i < 127; i++) begin
            if (i == 50) load_start = 1'b1;
            send(16'(2 * i), 16'(2 * i + 1));
            load_start = 1'b0;
        end
        init_done = 1'b1;
        load_start = 1'b1;
        send(16'd254, 16'd255);
        load_start = 1'b0;
        init_done = 1'b0;
        chk("t6_ready_after_last", 64'(s_ready), 64'd0);
        s_data = 32'h1234_5678;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_ready_extra", 64'(s_ready), 64'd0);
        end
        chk("t6_early_init_ignored", {62'd0, load_busy, load_done}, 64'd2);
        s_valid = 1'b0;
        finish_init(1);

        chk("final_queue", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
